seg_display_driver: RTL and testbench

Display consumer for the 0..99 counter value: converts the 7-bit binary count to two BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives the board's 4-digit multiplexed, active-low 7-segment display. Sits between the counter and the top-level pins. Registered outputs only.

---
 rtl/seg_pkg.sv | 46 ++++
 rtl/seg_display_driver_bin2bcd_seq.sv | 91 +++++++++
 rtl/seg_display_driver.sv | 143 ++++++++++++++
 tb/tb_seg_display_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit 7-segment display driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_COUNT  = 99;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // BCD digit to active-low segment pattern; non-decimal codes render blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to two BCD digits.
// One capture cycle, seven shift cycles, one DONE cycle.
//
// state | meaning
// IDLE  | waiting for start; captures bin on start
// SHIFT | add-3 adjust then shift in next MSB, 7 cycles (bit_cnt 6..0)
// DONE  | result stable on tens/ones for one cycle, done asserted
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bin,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd_state_t state_q, state_d;
  logic [6:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       busy_q, busy_d;
  logic [7:0] adj;

  // Next-state and datapath for the shift-add-3 engine.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    adj       = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_d     = bin;
          bcd_d     = '0;
          bit_cnt_d = 3'd6;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        // Overflow beyond two digits only happens for values >99, whose
        // result the display discards.
        bcd_d = {adj[6:0], bin_q[bit_cnt_q]};
        if (bit_cnt_q == 3'd0) begin
          state_d = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == DONE);
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed 7-segment display driver for a 0..99 count.
// Owns change detection, digit scan and segment decode; conversion is in
// bin2bcd_seq. Values 100..127 show a dash on both active digits.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [6:0]       last_val_q, last_val_d;
  logic             valid_q, valid_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             oor_q, oor_d;
  logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic       conv_start;
  logic       conv_busy;
  logic       conv_done;
  logic [3:0] conv_tens;
  logic [3:0] conv_ones;

  // A new conversion is launched only from idle; changes during a
  // conversion are caught afterwards by the last_val compare.
  assign conv_start = !conv_busy && (!valid_q || (value != last_val_q));

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (value),
    .start (conv_start),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Change capture and commit of the converted digits.
  always_comb begin
    last_val_d = last_val_q;
    valid_d    = valid_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    oor_d      = oor_q;
    if (conv_start) last_val_d = value;
    if (conv_done) begin
      tens_d  = conv_tens;
      ones_d  = conv_ones;
      oor_d   = (last_val_q > 7'(MAX_COUNT));
      valid_d = 1'b1;
    end
  end

  // Refresh counter and digit index for the scan.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (refresh_cnt_q == CNT_MAX) begin
      refresh_cnt_d = '0;
      idx_d         = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Segment/anode decode for the current slot from committed digits.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    if (valid_q) begin
      case (idx_q)
        IDX_W'(0): begin
          an_d  = 4'b1110;
          seg_d = oor_q ? SEG_DASH : bcd_to_seg(ones_q);
        end
        IDX_W'(1): begin
          an_d  = 4'b1101;
          seg_d = oor_q ? SEG_DASH : bcd_to_seg(tens_q);
`ifdef SEG_LEADING_ZERO_BLANK_EN
          if (!oor_q && (tens_q == 4'd0)) begin
            an_d  = 4'hF;
            seg_d = SEG_BLANK;
          end
`endif
        end
        default: begin
          an_d  = 4'hF;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  // All state and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_val_q    <= '0;
      valid_q       <= 1'b0;
      tens_q        <= '0;
      ones_q        <= '0;
      oor_q         <= 1'b0;
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'hF;
      dp_q          <= 1'b1;
    end else begin
      last_val_q    <= last_val_d;
      valid_q       <= valid_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      oor_q         <= oor_d;
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = conv_busy;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with a behavioural reference
// model (arithmetic /10 and %10, a busy timer and a scan counter).
module tb_seg_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] value;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  always #5 clk = ~clk;

  seg_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .busy  (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] code_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  int m_timer, m_cap, m_last, m_tens, m_ones, m_rc, m_idx;
  bit m_valid, m_oor;
  logic [6:0] want_seg;
  logic [3:0] want_an;
  logic       want_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_cap = 0; m_last = 0; m_tens = 0; m_ones = 0;
    m_rc = 0; m_idx = 0; m_valid = 0; m_oor = 0;
    want_seg = 7'h7F; want_an = 4'hF; want_busy = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    want_seg = 7'h7F;
    want_an  = 4'hF;
    if (m_valid) begin
      if (m_idx == 0) begin
        want_an  = 4'b1110;
        want_seg = m_oor ? 7'h3F : code_tab[m_ones];
      end else if (m_idx == 1) begin
        want_an  = 4'b1101;
        want_seg = m_oor ? 7'h3F : code_tab[m_tens];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (!m_oor && m_tens == 0) begin
          want_an  = 4'hF;
          want_seg = 7'h7F;
        end
`endif
      end
    end
    if (m_timer == 0) begin
      if (!m_valid || int'(value) != m_last) begin
        m_timer = 8;
        m_cap   = int'(value);
        m_last  = int'(value);
      end
    end else begin
      m_timer--;
      if (m_timer == 0) begin
        m_tens  = m_cap / 10;
        m_ones  = m_cap % 10;
        m_oor   = (m_cap > 99);
        m_valid = 1;
      end
    end
    want_busy = (m_timer != 0);
    if (m_rc == DIV - 1) begin
      m_rc  = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_rc++;
    end
  endtask

  task automatic cyc(input logic [6:0] v, input logic r);
    @(negedge clk);
    value = v;
    rst_n = r;
    @(posedge clk);
    model_step();
    #1;
    chk("seg", 32'(seg), 32'(want_seg));
    chk("an", 32'(an), 32'(want_an));
    chk("dp", 32'(dp), 32'd1);
    chk("busy", 32'(busy), 32'(want_busy));
  endtask

  initial begin
    int bc;
    int v;
    int hold;
    logic r;
    int edge_vals [7] = '{0, 7, 9, 10, 99, 100, 127};

    rst_n = 1'b0;
    value = 7'd0;
    model_reset();
    repeat (3) cyc(7'd0, 1'b0);

    // value 41 after reset: busy for exactly 8 cycles, then 1/4 on display
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(7'd41, 1'b1);
      if (busy) bc++;
    end
    chk("busy_len", 32'(bc), 32'd8);
    repeat (20) cyc(7'd41, 1'b1);

    // 99 then step to 0
    repeat (30) cyc(7'd99, 1'b1);
    repeat (30) cyc(7'd0, 1'b1);

    // out of range then back into range
    repeat (30) cyc(7'd105, 1'b1);
    repeat (30) cyc(7'd12, 1'b1);

    // changes on consecutive cycles during a conversion
    repeat (20) cyc(7'd40, 1'b1);
    cyc(7'd41, 1'b1);
    cyc(7'd42, 1'b1);
    cyc(7'd43, 1'b1);
    repeat (30) cyc(7'd43, 1'b1);

    // reset pulse mid-shift
    cyc(7'd77, 1'b1);
    repeat (3) cyc(7'd77, 1'b1);
    cyc(7'd77, 1'b0);
    repeat (30) cyc(7'd77, 1'b1);

    // boundary values
    foreach (edge_vals[k]) begin
      repeat (25) cyc(7'(edge_vals[k]), 1'b1);
    end

    // randomized values, hold lengths and occasional resets
    for (int n = 0; n < 80; n++) begin
      v    = int'($urandom_range(0, 127));
      hold = int'($urandom_range(1, 25));
      for (int h = 0; h < hold; h++) begin
        r = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        cyc(7'(v), r);
      end
    end
    repeat (20) cyc(value, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
